// File: rtl/serial_operand_serializer_pkg.sv
// Shared types and constants for the bit-serial operand serializer.
package serial_pkg;

    localparam int unsigned SER_W = 8;

    function automatic int unsigned ser_len_w(input int unsigned w);
        return $clog2(w + 1);
    endfunction

    localparam int unsigned SER_LEN_W = ser_len_w(SER_W);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    typedef struct packed {
        logic [SER_W-1:0]     a;
        logic [SER_W-1:0]     b;
        logic [SER_LEN_W-1:0] len;
    } ser_word_t;

endpackage

// File: rtl/serial_operand_serializer_if.sv
// Word-side handshake plus bit-serial output bundle of the serializer.
interface serial_operand_serializer_if
    import serial_pkg::*;
#(
    parameter int unsigned W = SER_W
);
    localparam int unsigned LEN_W = ser_len_w(W);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_a;
    logic [W-1:0]     in_b;
    logic [LEN_W-1:0] in_len;
    logic             stall;
    logic             vld;
    logic             a;
    logic             b;
    logic             last;

    modport master (
        output in_valid, in_a, in_b, in_len, stall,
        input  in_ready, vld, a, b, last
    );

    modport slave (
        input  in_valid, in_a, in_b, in_len, stall,
        output in_ready, vld, a, b, last
    );

endinterface

// File: rtl/serial_operand_serializer_hold.sv
// One-entry word holding register with full flag, used only for prefetch.
module serial_word_hold_reg
    import serial_pkg::*;
(
    input  logic      clk,
    input  logic      rst_n,
    input  logic      wr_en_i,
    input  ser_word_t word_i,
    input  logic      rd_en_i,
    output logic      full_o,
    output ser_word_t word_o
);

    logic      full_q, full_d;
    ser_word_t word_q, word_d;

    always_comb begin
        full_d = full_q;
        word_d = word_q;
        if (rd_en_i) begin
            full_d = 1'b0;
        end
        if (wr_en_i) begin
            full_d = 1'b1;
            word_d = word_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
            word_q <= '0;
        end else begin
            full_q <= full_d;
            word_q <= word_d;
        end
    end

    assign full_o = full_q;
    assign word_o = word_q;

endmodule

// File: rtl/serial_operand_serializer.sv
// Word-to-bit-serial operand feeder, LSB first with last flag and stall.
// Define SERIALIZER_PREFETCH_EN to add a one-word holding register for gapless streams.
module serial_operand_serializer
    import serial_pkg::*;
#(
    parameter int unsigned W = SER_W
) (
    input  logic                        clk,
    input  logic                        rst_n,
    serial_operand_serializer_if.slave  bus
);

    localparam int unsigned LEN_W = ser_len_w(W);

    ser_state_t       state_q, state_d;
    logic [W-1:0]     sh_a_q, sh_a_d;
    logic [W-1:0]     sh_b_q, sh_b_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic             ready_q, ready_d;

    logic             vld_c;
    logic             last_c;
    logic             accept_c;
    logic             load_c;
    logic [W-1:0]     ld_a_c;
    logic [W-1:0]     ld_b_c;
    logic [LEN_W-1:0] ld_len_c;

    // Zero and oversize lengths both mean a full-width word.
    function automatic logic [LEN_W-1:0] eff_len(input logic [LEN_W-1:0] len);
        if ((len == '0) || (32'(len) > W)) begin
            return LEN_W'(W);
        end
        return len;
    endfunction

    assign vld_c    = (state_q == SHIFT) && !bus.stall;
    assign last_c   = vld_c && (cnt_q == '0);
    assign accept_c = bus.in_valid && ready_q;

`ifdef SERIALIZER_PREFETCH_EN
    logic      hold_full;
    ser_word_t hold_word;
    ser_word_t hold_in_c;
    logic      take_in_c;
    logic      take_hold_c;
    logic      hold_wr_c;

    assign hold_in_c = '{a: SER_W'(bus.in_a), b: SER_W'(bus.in_b),
                         len: SER_LEN_W'(eff_len(bus.in_len))};

    serial_word_hold_reg u_hold (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en_i (hold_wr_c),
        .word_i  (hold_in_c),
        .rd_en_i (take_hold_c),
        .full_o  (hold_full),
        .word_o  (hold_word)
    );
`endif

    always_comb begin
        state_d  = state_q;
        sh_a_d   = sh_a_q;
        sh_b_d   = sh_b_q;
        cnt_d    = cnt_q;
        ready_d  = 1'b0;
        load_c   = 1'b0;
        ld_a_c   = bus.in_a;
        ld_b_c   = bus.in_b;
        ld_len_c = eff_len(bus.in_len);
`ifdef SERIALIZER_PREFETCH_EN
        // A retiring word hands over to the held word first, else to a fresh input.
        take_hold_c = last_c && hold_full;
        take_in_c   = accept_c && ((state_q == IDLE) || (last_c && !hold_full));
        hold_wr_c   = accept_c && !take_in_c;
        load_c      = take_in_c || take_hold_c;
        if (take_hold_c) begin
            ld_a_c   = W'(hold_word.a);
            ld_b_c   = W'(hold_word.b);
            ld_len_c = LEN_W'(hold_word.len);
        end
        ready_d = !(hold_wr_c || (hold_full && !take_hold_c));
`else
        load_c = accept_c;
`endif
        if (vld_c) begin
            sh_a_d = sh_a_q >> 1;
            sh_b_d = sh_b_q >> 1;
            cnt_d  = cnt_q - LEN_W'(1);
            if (last_c) begin
                state_d = IDLE;
            end
        end
        if (load_c) begin
            state_d = SHIFT;
            sh_a_d  = ld_a_c;
            sh_b_d  = ld_b_c;
            cnt_d   = ld_len_c - LEN_W'(1);
        end
`ifndef SERIALIZER_PREFETCH_EN
        ready_d = (state_d == IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sh_a_q  <= '0;
            sh_b_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sh_a_q  <= sh_a_d;
            sh_b_q  <= sh_b_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
        end
    end

    // Serial outputs depend only on registered state and the stall hold.
    assign bus.in_ready = ready_q;
    assign bus.vld      = vld_c;
    assign bus.a        = sh_a_q[0] && vld_c;
    assign bus.b        = sh_b_q[0] && vld_c;
    assign bus.last     = last_c;

endmodule

// File: tb/tb_serial_operand_serializer.sv
// Scoreboard bench for serial_operand_serializer; honours SERIALIZER_PREFETCH_EN.
module tb_serial_operand_serializer;

    typedef struct packed {
        logic a;
        logic b;
        logic last;
    } exp_t;

`ifdef SERIALIZER_PREFETCH_EN
    localparam int EXP_GAP = 0;
    localparam bit PREFETCH = 1'b1;
`else
    localparam int EXP_GAP = 1;
    localparam bit PREFETCH = 1'b0;
`endif

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;
    exp_t exp_q[$];
    int   idle_run = 0;
    int   gap_at_start = -1;
    bit   word_start = 1'b1;

    serial_operand_serializer_if #(.W(8)) bus ();

    serial_operand_serializer #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected bits come from the operands LSB first, last on the final bit.
    task automatic send(input logic [7:0] av, input logic [7:0] bv, input logic [3:0] lv);
        int   eff;
        int   n;
        exp_t e;
        eff = ((lv == 4'd0) || (lv > 4'd8)) ? 8 : int'(lv);
        for (int i = 0; i < eff; i++) begin
            e.a    = av[i];
            e.b    = bv[i];
            e.last = (i == eff - 1);
            exp_q.push_back(e);
        end
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_a     = av;
        bus.in_b     = bv;
        bus.in_len   = lv;
        n = 0;
        while (!bus.in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("accept_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (((exp_q.size() != 0) || bus.vld) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain_timeout", 32'(n >= 200), 32'd0);
        @(negedge clk);
    endtask

    // Monitor: compare every valid serial bit against the scoreboard head.
    always @(negedge clk) begin
        exp_t e;
        if (bus.vld) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_bit", 32'(1), 32'(0));
            end else begin
                e = exp_q.pop_front();
                chk("serial_bits{a,b,last}", 32'({bus.a, bus.b, bus.last}), 32'(e));
            end
            if (word_start) gap_at_start = idle_run;
            word_start = bus.last;
            idle_run   = 0;
            if (!PREFETCH) chk("ready_low_while_shifting", 32'(bus.in_ready), 32'd0);
        end else begin
            idle_run++;
            chk("idle_outputs{a,b,last}", 32'({bus.a, bus.b, bus.last}), 32'd0);
        end
    end

    initial begin
        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_a     = '0;
        bus.in_b     = '0;
        bus.in_len   = '0;
        bus.stall    = 1'b0;
        #12;
        chk("rst_vld", 32'(bus.vld), 32'd0);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_release", 32'(bus.in_ready), 32'd1);

        // Full word: a=0,1,1,0,1,0,0,1 b=1,0,0,1,0,1,1,0
        send(8'h96, 8'h69, 4'd8);
        wait_drain();
        // Short word: a=1,0,1 b=1,1,0
        send(8'h05, 8'h03, 4'd3);
        wait_drain();
        // Zero length and oversize length both emit 8 bits
        send(8'hA5, 8'h3C, 4'd0);
        wait_drain();
        send(8'hC3, 8'h5A, 4'd15);
        wait_drain();

        // Single-bit word, stalled on its last bit for two cycles
        send(8'h01, 8'h00, 4'd1);
        bus.stall = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("stall_last_vld", 32'(bus.vld), 32'd0);
        end
        chk("stall_last_not_retired", 32'(exp_q.size()), 32'd1);
        bus.stall = 1'b0;
        wait_drain();

        // Mid-word stall on bit 2 for three cycles
        send(8'hB4, 8'h4B, 4'd8);
        @(posedge clk);
        @(posedge clk);
        #1;
        bus.stall = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("stall_mid_vld", 32'(bus.vld), 32'd0);
        end
        @(posedge clk);
        #1;
        bus.stall = 1'b0;
        wait_drain();

        // Stall while idle does not block acceptance
        bus.stall = 1'b1;
        send(8'h3C, 8'hC3, 4'd4);
        bus.stall = 1'b0;
        wait_drain();

        // Back-to-back words
        send(8'hF0, 8'h0F, 4'd8);
        send(8'h81, 8'h7E, 4'd8);
        chk("ready_low_after_second", 32'(bus.in_ready), 32'd0);
        wait_drain();
        chk("b2b_gap", 32'(gap_at_start), 32'(EXP_GAP));

        // Reset in the middle of a word
        send(8'hFF, 8'h00, 4'd8);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midreset_vld", 32'(bus.vld), 32'd0);
        chk("midreset_ready", 32'(bus.in_ready), 32'd0);
        chk("midreset_bits_seen", 32'(exp_q.size()), 32'd5);
        exp_q.delete();
        word_start = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("ready_after_midreset", 32'(bus.in_ready), 32'd1);
        send(8'h5A, 8'hA5, 4'd8);
        wait_drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
